// File: rtl/mult_div_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_seq_if
// Purpose  : Handshake and operand/result bundle between the CPU control unit
//            (master) and the sequential HI/LO multiply/divide unit (slave).
// Signals  : start        launch request, sampled by the unit only when idle
//            op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//            a, b         multiplicand/dividend, multiplier/divisor
//            hi, lo       product upper/lower half, or remainder/quotient
//            busy         operation in flight
//            done         one-cycle completion pulse
//            div_by_zero  sticky flag from the last completion
// Revision : 1.0 - initial release
// ============================================================================
interface mult_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  // Control unit side: issues operations, observes results.
  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div_by_zero
  );

  // Arithmetic unit side.
  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/mult_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_seq
// Purpose  : Sequential signed/unsigned multiply (radix-2 shift-add) and
//            divide (restoring) unit for the HI/LO datapath. Both algorithms
//            operate on operand magnitudes; signs are restored at the end.
//            Fixed latency of WIDTH+1 cycles from acceptance to done, except
//            divide-by-zero (and early-out cases, if enabled), which finish
//            one cycle after acceptance.
// Ports    : clock        system clock
//            reset        synchronous, active-high reset
//            bus          mult_div_seq_if.slave (start/op/a/b in,
//                         hi/lo/busy/done/div_by_zero out)
// Config   : MULT_DIV_EARLY_OUT_EN - when defined, DIV/DIVU with |a| < |b|
//            (b != 0) and MULT/MULTU with a zero operand finish after one
//            cycle. Results are identical; only latency changes.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  mult_div_seq_if.slave bus
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_ITER = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t r_state;

  // Operation context latched at acceptance.
  logic               r_is_div;
  logic               r_neg_q;     // negate product (mult) / quotient (div)
  logic               r_neg_r;     // negate remainder (div only)
  logic               r_dbz_pend;  // divide-by-zero result waiting in FINISH
  logic [WIDTH-1:0]   r_opnd;      // |multiplicand| or |divisor|

  // Shared working pair: {product hi, multiplier/product lo} for multiply,
  // {partial remainder, dividend/quotient} for divide.
  logic [WIDTH-1:0]   r_p_hi;
  logic [WIDTH-1:0]   r_p_lo;
  logic [c_CNT_W-1:0] r_cnt;

  // Registered outputs.
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  // --------------------------------------------------------------------------
  // Acceptance-time decode: magnitudes and sign flags of the new operands.
  // --------------------------------------------------------------------------
  logic             w_signed;
  logic             w_div;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_b_zero;
  logic             w_dbz;
  logic             w_early;

  assign w_signed = ~bus.op[0];
  assign w_div    = bus.op[1];
  assign w_a_neg  = w_signed & bus.a[WIDTH-1];
  assign w_b_neg  = w_signed & bus.b[WIDTH-1];
  // The most-negative value maps onto itself, which is the correct unsigned
  // magnitude 2^(WIDTH-1).
  assign w_mag_a  = w_a_neg ? -bus.a : bus.a;
  assign w_mag_b  = w_b_neg ? -bus.b : bus.b;
  assign w_b_zero = (bus.b == '0);
  assign w_dbz    = w_div & w_b_zero;

`ifdef MULT_DIV_EARLY_OUT_EN
  // Quotient is trivially zero when the dividend magnitude is smaller than
  // the divisor's; a product with a zero operand is zero.
  assign w_early = w_div ? (~w_b_zero & (w_mag_a < w_mag_b))
                         : ((bus.a == '0) | w_b_zero);
`else
  assign w_early = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // One iteration of each algorithm.
  // --------------------------------------------------------------------------
  // Shift-add: add the multiplicand when the current multiplier bit is set,
  // then shift the whole {hi, lo} pair right, carry included.
  logic [WIDTH:0]   w_add_sum;
  assign w_add_sum = {1'b0, r_p_hi} + {1'b0, (r_p_lo[0] ? r_opnd : '0)};

  // Restoring divide: shift the next dividend bit into the remainder and
  // trial-subtract the divisor. The remainder is always below the divisor,
  // so WIDTH+1 bits suffice and the MSB of the difference is the borrow.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_q_bit;
  assign w_shift = {r_p_hi, r_p_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_opnd};
  assign w_q_bit = ~w_diff[WIDTH];

  // --------------------------------------------------------------------------
  // Sign correction applied in FINISH.
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_prod     = {r_p_hi, r_p_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg_q ? -r_p_lo : r_p_lo;
  assign w_rem_fix  = r_neg_r ? -r_p_hi : r_p_hi;

  // --------------------------------------------------------------------------
  // Control FSM and datapath registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_opnd     <= '0;
      r_p_hi     <= '0;
      r_p_lo     <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy     <= 1'b1;
            r_is_div   <= w_div;
            r_dbz_pend <= w_dbz;
            r_cnt      <= '0;
            r_opnd     <= w_div ? w_mag_b : w_mag_a;
            if (w_dbz) begin
              // Preload the fixed divide-by-zero result and bypass sign
              // correction so FINISH writes it through unchanged.
              r_p_hi  <= bus.a;
              r_p_lo  <= '1;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              if (w_early) begin
                // Quotient 0 with remainder |a| (restored to a by the
                // dividend sign), or a zero product.
                r_p_hi <= w_div ? w_mag_a : '0;
                r_p_lo <= '0;
              end else begin
                r_p_hi <= '0;
                r_p_lo <= w_div ? w_mag_a : w_mag_b;
              end
            end
            r_state <= (w_dbz || w_early) ? S_FINISH : S_RUN;
          end
        end

        S_RUN: begin
          if (r_is_div) begin
            r_p_hi <= w_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_p_lo <= {r_p_lo[WIDTH-2:0], w_q_bit};
          end else begin
            r_p_hi <= w_add_sum[WIDTH:1];
            r_p_lo <= {w_add_sum[0], r_p_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST_ITER) begin
            r_state <= S_FINISH;
          end
        end

        S_FINISH: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_dbz   <= r_dbz_pend;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_seq
// Purpose  : Self-checking bench for mult_div_seq (WIDTH=32). A driver issues
//            directed and random operations and pushes the expected result
//            (computed with plain 64-bit arithmetic) onto a scoreboard queue;
//            a monitor pops and compares on every done pulse and checks
//            busy/hold behaviour on all other cycles.
// Config   : honours MULT_DIV_EARLY_OUT_EN for expected latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_seq;

  localparam int W = 32;
`ifdef MULT_DIV_EARLY_OUT_EN
  localparam bit c_EARLY = 1'b1;
`else
  localparam bit c_EARLY = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mult_div_seq_if #(.WIDTH(W)) bus ();

  mult_div_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    longint       acc;
  } exp_t;

  exp_t         sb_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  longint       cyc     = 0;
  bit           mon_en  = 1'b0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  logic         last_dbz = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: results from the arithmetic definition of each op.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t        e;
    longint      sa;
    longint      sbv;
    longint      ma;
    longint      mb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sbv < 0) ? -sbv : sbv;
    e.dbz = 1'b0;
    e.lat = W + 1;
    e.acc = 0;
    e.hi  = '0;
    e.lo  = '0;
    case (op)
      2'b00, 2'b01: begin
        if (op == 2'b00) p = sa * sbv;
        else             p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
        if (c_EARLY && (a == 0 || b == 0)) e.lat = 1;
      end
      default: begin
        if (b == 0) begin
          e.hi  = a;
          e.lo  = '1;
          e.dbz = 1'b1;
          e.lat = 1;
        end else if (op == 2'b10) begin
          q = sa / sbv;   // truncates toward zero; remainder follows dividend
          r = sa % sbv;
          e.lo = q[31:0];
          e.hi = r[31:0];
          if (c_EARLY && ma < mb) e.lat = 1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
          if (c_EARLY && a < b) e.lat = 1;
        end
      end
    endcase
    return e;
  endfunction

  task automatic wait_cycle();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation as soon as the unit is idle. Optionally hold start
  // high with junk operands for a few busy cycles afterwards.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int junk_cycles);
    exp_t e;
    int   guard;
    guard = 0;
    while (bus.busy) begin
      wait_cycle();
      guard++;
      if (guard > 200) begin
        chk("busy_timeout", 64'(bus.busy), 64'd0);
        return;
      end
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    e = model(op, a, b);
    wait_cycle();
    e.acc = cyc;
    sb_q.push_back(e);
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    for (int i = 0; i < junk_cycles; i++) begin
      bus.start = 1'b1;
      bus.op    = 2'($urandom);
      bus.a     = $urandom;
      bus.b     = $urandom;
      wait_cycle();
    end
    bus.start = 1'b0;
  endtask

  // Monitor / scoreboard checker.
  always @(negedge clock) begin
    exp_t e;
    if (mon_en && !reset) begin
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("hi", 64'(bus.hi), 64'(e.hi));
          chk("lo", 64'(bus.lo), 64'(e.lo));
          chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("busy_at_done", 64'(bus.busy), 64'd0);
          last_hi  = e.hi;
          last_lo  = e.lo;
          last_dbz = e.dbz;
        end
      end else begin
        chk("busy", 64'(bus.busy), 64'(sb_q.size() != 0));
        chk("hold_hi", 64'(bus.hi), 64'(last_hi));
        chk("hold_lo", 64'(bus.lo), 64'(last_lo));
        chk("hold_dbz", 64'(bus.div_by_zero), 64'(last_dbz));
      end
    end
  end

  function automatic logic [W-1:0] rand_opnd();
    logic [W-1:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 5))
      0:       return corners[$urandom_range(0, 4)];
      1:       return W'($urandom_range(0, 20));
      2:       return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int guard;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) wait_cycle();
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Directed cases.
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 0);
    issue(2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    issue(2'b10, 32'd5, 32'd0, 0);
    issue(2'b00, 32'd2, 32'd3, 0);
    issue(2'b11, 32'd3, 32'd10, 0);
    issue(2'b00, 32'd0, 32'h1234_5678, 0);
    // start toggling with junk operands while busy must not disturb this op.
    issue(2'b00, 32'h0001_2345, 32'hFFFF_0F0F, 8);
    issue(2'b11, 32'd9, 32'd0, 0);

    // Reset in the middle of a multiply: everything clears, no done follows.
    issue(2'b00, 32'd12345, 32'd678, 0);
    repeat (9) wait_cycle();
    reset = 1'b1;
    wait_cycle();
    chk("midreset_hi", 64'(bus.hi), 64'd0);
    chk("midreset_lo", 64'(bus.lo), 64'd0);
    chk("midreset_busy", 64'(bus.busy), 64'd0);
    chk("midreset_done", 64'(bus.done), 64'd0);
    chk("midreset_dbz", 64'(bus.div_by_zero), 64'd0);
    sb_q.delete();
    last_hi  = '0;
    last_lo  = '0;
    last_dbz = 1'b0;
    reset = 1'b0;
    repeat (40) wait_cycle();

    // Randomised operations, issued back-to-back.
    for (int n = 0; n < 150; n++) begin
      issue(2'($urandom), rand_opnd(), rand_opnd(), 0);
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      wait_cycle();
      guard++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    repeat (3) wait_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
